// File: rtl/fc_mvm_par.sv
// Fully-connected layer y = W*x with P parallel MAC lanes, weights held on chip.
// Optional FC_RELU_EN macro clamps negative saturated results to zero.
module fc_mvm_par #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int T = 16,
  parameter int P = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic signed [T-1:0] w_data,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data
);

  localparam int AW = 2 * T + $clog2(N);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N + 1);
  localparam int LW = (P > 1) ? $clog2(P) : 1;

  generate
    if ((M % P) != 0) begin : g_bad_lanes
      $error("fc_mvm_par: M must be a multiple of P");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD_W, LOAD_X, COMPUTE, DRAIN} state_t;

  state_t              state;
  logic signed [T-1:0] w_mem [M][N];
  logic signed [T-1:0] x_mem [N];
  logic [RW-1:0]       wrow;
  logic [RW-1:0]       base;
  logic [CW-1:0]       wcol;
  logic [CW-1:0]       xcnt;
  logic [KW-1:0]       cnt;
  logic [LW-1:0]       lane;
  logic signed [T-1:0]    wr [P];
  logic signed [T-1:0]    xr;
  logic signed [2*T-1:0]  prod [P];
  logic signed [AW-1:0]   acc [P];
  logic signed [AW-1:0]   acc_next [P];
  logic                w_fire;
  logic                x_fire;

  assign w_fire = (state == LOAD_W) && w_valid && w_ready;
  assign x_fire = (state == LOAD_X) && input_valid && input_ready;

  // Clamp to the signed T-bit range; ReLU only exists when enabled.
  function automatic logic signed [T-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] lo;
    logic signed [T-1:0]  r;
    hi = {{(AW - T + 1){1'b0}}, {(T - 1){1'b1}}};
    lo = {{(AW - T + 1){1'b1}}, {(T - 1){1'b0}}};
    if (a > hi) r = hi[T-1:0];
    else if (a < lo) r = lo[T-1:0];
    else r = a[T-1:0];
`ifdef FC_RELU_EN
    if (r[T-1]) r = '0;
`endif
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset && w_fire) w_mem[wrow][wcol] <= w_data;
    if (!reset && x_fire) x_mem[xcnt] <= input_data;
  end

  // Operand fetch for the current column; the first COMPUTE cycle only reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < P; k++) wr[k] <= '0;
      xr <= '0;
    end else if (state == COMPUTE) begin
      for (int k = 0; k < P; k++) wr[k] <= w_mem[base + RW'(k)][cnt[CW-1:0]];
      xr <= x_mem[cnt[CW-1:0]];
    end
  end

  always_comb begin
    for (int k = 0; k < P; k++) begin
      prod[k]     = (2 * T)'(wr[k]) * (2 * T)'(xr);
      acc_next[k] = acc[k] + AW'(prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD_W;
      w_ready      <= 1'b1;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      output_data  <= '0;
      wrow         <= '0;
      wcol         <= '0;
      xcnt         <= '0;
      cnt          <= '0;
      base         <= '0;
      lane         <= '0;
      for (int k = 0; k < P; k++) acc[k] <= '0;
    end else begin
      case (state)
        LOAD_W: begin
          if (w_fire) begin
            if (wcol == CW'(N - 1)) begin
              wcol <= '0;
              if (wrow == RW'(M - 1)) begin
                wrow        <= '0;
                state       <= LOAD_X;
                w_ready     <= 1'b0;
                input_ready <= 1'b1;
              end else begin
                wrow <= wrow + RW'(1);
              end
            end else begin
              wcol <= wcol + CW'(1);
            end
          end
        end
        LOAD_X: begin
          if (x_fire) begin
            if (xcnt == CW'(N - 1)) begin
              xcnt        <= '0;
              cnt         <= '0;
              base        <= '0;
              input_ready <= 1'b0;
              state       <= COMPUTE;
            end else begin
              xcnt <= xcnt + CW'(1);
            end
          end
        end
        COMPUTE: begin
          for (int k = 0; k < P; k++) acc[k] <= (cnt == '0) ? '0 : acc_next[k];
          if (cnt == KW'(N)) begin
            state        <= DRAIN;
            lane         <= '0;
            output_valid <= 1'b1;
            output_data  <= sat(acc_next[0]);
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        DRAIN: begin
          if (output_valid && output_ready) begin
            if (lane == LW'(P - 1)) begin
              output_valid <= 1'b0;
              cnt          <= '0;
              if (base == RW'(M - P)) begin
                state       <= LOAD_X;
                input_ready <= 1'b1;
              end else begin
                base  <= base + RW'(P);
                state <= COMPUTE;
              end
            end else begin
              lane        <= lane + LW'(1);
              output_data <= sat(acc[lane + LW'(1)]);
            end
          end
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule
